and_rr_sched: RTL
=================

// Module: and_rr_sched
// PURPOSE
//  Round-robin scheduler sharing one and_gate datapath among NumReq requesters
//  (e.g. CPU bus slave, DMA).
//  - Accepts one operand pair at a time via valid/ready.
//  - Sequences the gate's enable/valid protocol.
//  - Returns the result to the winning requester. Times out if the gate stalls.
// PARAMETERS
//  NumReq      2   number of requesters, >=2
//  DataWidth   16  operand/result width
//  TimeoutCyc  15  max WAIT cycles before abort, 1..255
// PORTS
//  clk          in   1                 clock
//  rst_ni       in   1                 reset, asynchronous, active-low
//  req_valid_i  in   NumReq            per-requester operand valid
//  req_ready_o  out  NumReq            one-hot accept pulse
//  req_a_i      in   NumReq*DataWidth  operand A, requester i at [i*DW +: DW]
//  req_b_i      in   NumReq*DataWidth  operand B, same packing
//  rsp_valid_o  out  NumReq            one-hot result valid
//  rsp_ready_i  in   NumReq            per-requester result accept
//  rsp_data_o   out  DataWidth         result, shared by all requesters
//  rsp_err_o    out  1                 qualifies rsp_valid_o: 1 = timed out, data 0
//  gate_en_o    out  1                 enable to and_gate
//  gate_a_o     out  DataWidth         operand A to gate
//  gate_b_o     out  DataWidth         operand B to gate
//  gate_out_i   in   DataWidth         gate result
//  gate_valid_i in   1                 gate result valid
//  busy_o       out  1                 1 whenever state != IDLE
// BEHAVIOUR
//  Reset values (async, all registered):
//  - outputs: all 0.
//  - state: IDLE.
//  - rr pointer: NumReq-1, so requester 0 wins first.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE:
//    - Winner = first i with req_valid_i[i], scanning from ptr+1 modulo NumReq
//      (wrap-around).
//    - Same cycle, combinationally: req_ready_o[winner]=1, other bits 0.
//    - Latch operands and winner id. Next state ISSUE.
//    - No valid: stay IDLE, req_ready_o=0.
//  - ISSUE:
//    - gate_en_o=1 for exactly one cycle.
//    - gate_a_o/gate_b_o hold latched operands from ISSUE until the next accept.
//    - Clear timeout counter. Next state WAIT.
//  - WAIT:
//    - gate_valid_i=1: capture gate_out_i into rsp_data_o, rsp_err_o=0, go RESP.
//    - Else increment counter. On reaching TimeoutCyc: rsp_data_o=0,
//      rsp_err_o=1, go RESP.
//    - A gate_valid_i in the same cycle as the timeout wins (no error).
//  - RESP:
//    - rsp_valid_o[id]=1; data/err held stable until rsp_ready_i[id]=1.
//    - On that handshake: ptr<=id, rsp_valid_o<=0, next state IDLE.
//    - Earliest re-accept is the cycle after the handshake.
//    - rsp_ready_i of non-owners is ignored.
//  Handshake and fairness rules:
//  - Latency with a 1-cycle gate: accept at T, gate_en T+1, valid seen T+2,
//    rsp_valid T+3.
//  - gate_valid_i outside WAIT is ignored.
//  - Requests arriving while busy wait; req_valid_i must stay high until ready.
//  - Simultaneous requests: round-robin. A requester is never granted twice
//    while another holds valid continuously.
//  - Reset mid-operation aborts immediately: no response; gate_en_o drops
//    asynchronously.
// TESTING
//  1. Single request: req0 A=16'hF0F0 B=16'h3C3C, gate 1-cycle.
//     -> rsp_valid_o=01 at T+3, rsp_data_o=16'h3030, err=0.
//  2. Both requesters valid continuously, 4 jobs.
//     -> grant order 0,1,0,1; no back-to-back repeat grant.
//  3. Gate never asserts valid.
//     -> after 15 WAIT cycles, rsp_err_o=1, rsp_data_o=0, busy_o stays 1
//        until rsp_ready.
//  4. rsp_ready_i held 0 for 5 cycles.
//     -> rsp_valid/data stable; req1 valid meanwhile gets no ready until
//        1 cycle after handshake.
//  5. rst_ni low during WAIT.
//     -> all outputs 0 immediately; after release req0 wins first and
//        completes normally.
//  6. gate_valid_i on the timeout cycle with out=16'h00FF.
//     -> err=0, data=16'h00FF.

Source files
------------

// File: rtl/and_rr_sched.sv
// Round-robin scheduler that shares one and_gate datapath among NumReq requesters.
// It accepts one operand pair, runs the gate handshake, and returns the result or a timeout error.
module and_rr_sched #(
   parameter int NumReq     = 2,
   parameter int DataWidth  = 16,
   parameter int TimeoutCyc = 15
) (
   input  logic                          clk,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             req_valid_i,
   output logic [NumReq-1:0]             req_ready_o,
   input  logic [NumReq*DataWidth-1:0]   req_a_i,
   input  logic [NumReq*DataWidth-1:0]   req_b_i,
   output logic [NumReq-1:0]             rsp_valid_o,
   input  logic [NumReq-1:0]             rsp_ready_i,
   output logic [DataWidth-1:0]          rsp_data_o,
   output logic                          rsp_err_o,
   output logic                          gate_en_o,
   output logic [DataWidth-1:0]          gate_a_o,
   output logic [DataWidth-1:0]          gate_b_o,
   input  logic [DataWidth-1:0]          gate_out_i,
   input  logic                          gate_valid_i,
   output logic                          busy_o,
   output logic [1:0]                    dbg_state_o
);

   localparam int IdW = $clog2(NumReq);
   localparam logic [7:0] TimeoutVal = 8'(TimeoutCyc);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // req_ready_o is a combinational one-hot grant in IDLE; rsp_valid_o holds until the
   // owner's rsp_ready_i, and ready bits of other requesters are ignored.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [IdW-1:0]       ptr_q, ptr_d;
   logic [IdW-1:0]       id_q, id_d;
   logic [DataWidth-1:0] opa_q, opa_d;
   logic [DataWidth-1:0] opb_q, opb_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic                 err_q, err_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [7:0]           cnt_inc;

   logic [IdW-1:0]       winner;
   logic                 any_valid;
   logic [DataWidth-1:0] a_arr [NumReq];
   logic [DataWidth-1:0] b_arr [NumReq];

   for (genvar g = 0; g < NumReq; g++) begin : g_unpack
      assign a_arr[g] = req_a_i[g*DataWidth +: DataWidth];
      assign b_arr[g] = req_b_i[g*DataWidth +: DataWidth];
   end

   // Scan starts one past the last served requester, so the previous winner is checked last.
   always_comb begin
      int             idx;
      logic [IdW-1:0] idx_w;
      winner    = '0;
      any_valid = 1'b0;
      idx       = 0;
      idx_w     = '0;
      for (int k = 1; k <= NumReq; k++) begin
         idx   = (int'(ptr_q) + k) % NumReq;
         idx_w = IdW'(idx);
         if (!any_valid && req_valid_i[idx_w]) begin
            any_valid = 1'b1;
            winner    = idx_w;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         ptr_q   <= IdW'(NumReq - 1);
         id_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cnt_inc = cnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      data_d  = data_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (any_valid) begin
               id_d    = winner;
               opa_d   = a_arr[winner];
               opb_d   = b_arr[winner];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A gate result arriving on the timeout cycle still counts as a success.
            if (gate_valid_i) begin
               data_d  = gate_out_i;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TimeoutVal) begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (rsp_ready_i[id_q]) begin
               ptr_d   = id_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      if (state_q == S_IDLE && any_valid) begin
         req_ready_o[winner] = 1'b1;
      end
      if (state_q == S_RESP) begin
         rsp_valid_o[id_q] = 1'b1;
      end
      gate_en_o   = (state_q == S_ISSUE);
      busy_o      = (state_q != S_IDLE);
      dbg_state_o = state_q;
   end

   assign gate_a_o   = opa_q;
   assign gate_b_o   = opb_q;
   assign rsp_data_o = data_q;
   assign rsp_err_o  = err_q;

endmodule
